// File: rtl/core_pkg.sv
// Shared core types and defaults for the integer register file.
// No logic; types and constants only.
// No flow control.
package core_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] xword_t;

  // Architectural zero register index.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register pending bits, outstanding count, issue_ready.
// issue_ready/rs_busy combinational; pending/pend_cnt update at the rising edge.
// Issues arriving while issue_ready=0 are dropped; decode holds and retries. REGFILE_BYPASS_EN lets a same-cycle write free a register.
module regfile_scoreboard import core_pkg::*; #(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD-1:0]    rs_busy,
  output logic              issue_ready,
  output logic [AW:0]       pend_cnt
);

  logic [NREGS-1:0] pending;
  logic             clr;
  logic             wr_hits_issue;
  logic             accept;
  logic             inc;
  logic             dec;

  assign clr           = wr_en && (wr_addr != AW'(REG_ZERO));
  assign wr_hits_issue = clr && (wr_addr == issue_rd);

`ifdef REGFILE_BYPASS_EN
  assign issue_ready = (issue_rd == AW'(REG_ZERO)) || !pending[issue_rd] || wr_hits_issue;
`else
  assign issue_ready = (issue_rd == AW'(REG_ZERO)) || !pending[issue_rd];
`endif

  assign accept = issue_en && issue_ready && (issue_rd != AW'(REG_ZERO));
  // A set and clear on the same register leave it pending, so the clear must not count.
  assign inc    = accept && !pending[issue_rd];
  assign dec    = clr && pending[wr_addr] && !(accept && wr_hits_issue);

  // Per-port busy flag: source has an outstanding producer not covered by a same-cycle write.
  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] idx;
      idx = rs_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      rs_busy[k] = (idx != AW'(REG_ZERO)) && pending[idx] && !(clr && (wr_addr == idx));
`else
      rs_busy[k] = (idx != AW'(REG_ZERO)) && pending[idx];
`endif
    end
  end

  // Pending bits and counter: reset, then flush, then clear-before-set so a new producer wins.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (clr)    pending[wr_addr]  <= 1'b0;
      if (accept) pending[issue_rd] <= 1'b1;
      pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with hardwired x0, NRD read ports and a pending-write scoreboard.
// Reads combinational (zero latency); writes land at the rising edge.
// No backpressure on writes; issue throttled via issue_ready. Optional REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_sb import core_pkg::*; #(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs [NREGS];

  // Register storage; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read muxes: x0 reads zero, optional forwarding of the write in flight.
  always_comb begin
    rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] idx;
      idx = rs_addr[k*AW +: AW];
      if (idx == AW'(REG_ZERO)) begin
        rs_data[k*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en && (wr_addr == idx)) begin
        rs_data[k*XLEN +: XLEN] = wr_data;
`endif
      end else begin
        rs_data[k*XLEN +: XLEN] = regs[idx];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .rs_addr     (rs_addr),
    .rs_busy     (rs_busy),
    .issue_ready (issue_ready),
    .pend_cnt    (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (XLEN=32, NREGS=32, NRD=2).
// Inputs driven 1 time unit after the rising edge; outputs checked 1 unit later.
// Expected values are hand-computed; REGFILE_BYPASS_EN selects the bypass expectations.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                flush;
  logic [AW:0]         pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .pend_cnt    (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rd(input int k);
    return rs_data[k*XLEN +: XLEN];
  endfunction

  task automatic set_rs(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    reset = 1'b1; idle(); rs_addr = '0; wr_addr = '0; wr_data = '0; issue_rd = '0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // Reset state across every index on both ports.
    check("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    for (int i = 0; i < NREGS; i++) begin
      set_rs(i, NREGS-1-i);
      issue_rd = AW'(i);
      #1;
      check($sformatf("rst_rd0_x%0d", i), 64'(rd(0)), 64'd0);
      check($sformatf("rst_rd1_x%0d", i), 64'(rd(1)), 64'd0);
      check($sformatf("rst_busy_x%0d", i), 64'(rs_busy), 64'd0);
      check($sformatf("rst_ready_x%0d", i), 64'(issue_ready), 64'd1);
    end

    // Plain write then read.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick(); idle();
    set_rs(5, 0); #1;
    check("wr_x5", 64'(rd(0)), 64'hDEADBEEF);

    // Write to x0 is dropped.
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    tick(); idle();
    set_rs(0, 0); #1;
    check("x0_read", 64'(rd(0)), 64'd0);
    check("x0_pend_cnt", 64'(pend_cnt), 64'd0);

    // Same-cycle write/read on port 1.
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1234;
    set_rs(0, 7); #1;
    check("bypass_rd1", 64'(rd(1)), BYP ? 64'h1234 : 64'd0);
    tick(); idle(); #1;
    check("after_wr_x7", 64'(rd(1)), 64'h1234);

    // Issue x3, re-issue blocked, write clears.
    issue_en = 1'b1; issue_rd = 3; #1;
    check("x3_ready", 64'(issue_ready), 64'd1);
    tick(); idle();
    set_rs(3, 0); #1;
    check("x3_busy", 64'(rs_busy), 64'b01);
    check("x3_cnt1", 64'(pend_cnt), 64'd1);
    issue_en = 1'b1; issue_rd = 3; #1;
    check("x3_waw_ready", 64'(issue_ready), 64'd0);
    tick(); idle(); #1;
    check("x3_waw_cnt", 64'(pend_cnt), 64'd1);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33; #1;
    check("x3_busy_wr", 64'(rs_busy), BYP ? 64'b00 : 64'b01);
    tick(); idle(); #1;
    check("x3_cleared_cnt", 64'(pend_cnt), 64'd0);
    check("x3_cleared_busy", 64'(rs_busy), 64'b00);
    check("x3_data", 64'(rd(0)), 64'h33);

    // Issue and write x4 together: new producer owns it.
    issue_en = 1'b1; issue_rd = 4; wr_en = 1'b1; wr_addr = 4; wr_data = 32'h44;
    tick(); idle();
    set_rs(0, 4); #1;
    check("x4_cnt", 64'(pend_cnt), 64'd1);
    check("x4_busy", 64'(rs_busy), 64'b10);
    check("x4_data", 64'(rd(1)), 64'h44);

    // Three issues, then flush with a competing issue.
    issue_en = 1'b1;
    issue_rd = 1; tick();
    issue_rd = 2; tick();
    issue_rd = 9; tick();
    issue_en = 1'b0; #1;
    check("multi_cnt", 64'(pend_cnt), 64'd4);
    flush = 1'b1; issue_en = 1'b1; issue_rd = 10;
    tick(); idle();
    set_rs(10, 9); #1;
    check("flush_cnt", 64'(pend_cnt), 64'd0);
    check("flush_busy", 64'(rs_busy), 64'b00);
    check("flush_x10_ready", 64'(issue_ready), 64'd1);

    // Fill the scoreboard to its maximum.
    issue_en = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      issue_rd = AW'(i);
      tick();
    end
    issue_rd = 0; tick();
    issue_en = 1'b0; #1;
    check("full_cnt", 64'(pend_cnt), 64'd31);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h55;
    tick(); #1;
    check("full_dec", 64'(pend_cnt), 64'd30);
    tick(); idle(); #1;
    check("no_underflow", 64'(pend_cnt), 64'd30);
    // Write x6 while re-issuing it: only the bypass build frees it in the same cycle.
    wr_en = 1'b1; wr_addr = 6; wr_data = 32'h66; issue_en = 1'b1; issue_rd = 6; #1;
    check("x6_ready_wr", 64'(issue_ready), BYP ? 64'd1 : 64'd0);
    tick(); idle(); #1;
    check("x6_cnt", 64'(pend_cnt), BYP ? 64'd30 : 64'd29);

    // Reset mid-stream beats concurrent issue and write.
    reset = 1'b1; issue_en = 1'b1; issue_rd = 7; wr_en = 1'b1; wr_addr = 8; wr_data = 32'h88;
    tick();
    reset = 1'b0; idle();
    set_rs(5, 8); issue_rd = 7; #1;
    check("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    check("mid_rst_rd0", 64'(rd(0)), 64'd0);
    check("mid_rst_rd1", 64'(rd(1)), 64'd0);
    check("mid_rst_busy", 64'(rs_busy), 64'b00);
    check("mid_rst_ready", 64'(issue_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
